// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and legal parameter ranges.
// Used by the transmitter and intended for the matching receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time down-counter: reloads CLKS_PER_BIT-1 on request or after reaching 0,
// and flags the final cycle of each bit with a one-cycle tick.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (reload || (count_reg == '0)) begin
            count_reg <= RELOAD_VAL;
        end else begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign tick = (count_reg == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter (start, DATA_BITS LSB first, optional parity, stop bits).
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_cfg: CLKS_PER_BIT must be at least 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY_ODD must be 0 or 1");
    end

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e          state_reg, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic                 stop_cnt_reg, stop_cnt_next;
    logic                 tx_reg, tx_next;
    logic                 done_reg, done_next;
    logic                 reload;
    logic                 tick;
`ifdef UART_TX_PARITY_EN
    logic                 parity_reg, parity_next;
`endif

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .reload(reload),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            tx_reg       <= 1'b1;
            done_reg     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            tx_reg       <= tx_next;
            done_reg     <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= parity_next;
`endif
        end
    end

    // tx is registered, so each branch sets tx_next to the level of the state being entered.
    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        tx_next       = tx_reg;
        done_next     = 1'b0;
        reload        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next   = parity_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (tx_valid) begin
                    state_next    = ST_START;
                    shift_next    = tx_data;
                    bit_cnt_next  = '0;
                    stop_cnt_next = 1'b0;
                    tx_next       = 1'b0;
                    reload        = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_next   = (^tx_data) ^ PARITY_ODD[0];
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    state_next = ST_DATA;
                    tx_next    = shift_reg[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_reg == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
                        tx_next    = parity_reg;
`else
                        state_next = ST_STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        shift_next   = shift_reg >> 1;
                        tx_next      = shift_reg[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_next = ST_STOP;
                    tx_next    = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_cnt_reg == LAST_STOP) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        stop_cnt_next = stop_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    assign tx       = tx_reg;
    assign tx_done  = done_reg;
    assign tx_ready = (state_reg == ST_IDLE);
    assign tx_busy  = ~tx_ready;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four instances (8N1, 5-bit, 2 stop even/odd) checked every cycle
// against a frame-position model, plus hand-computed waveform points.
module tb_uart_tx_cfg;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int DB_P  [4] = '{8, 5, 8, 8};
    localparam int SB_P  [4] = '{1, 1, 2, 2};
    localparam int ODD_P [4] = '{0, 0, 0, 1};
    localparam int A5_SLOTS [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    localparam int W1B_SLOTS [6] = '{0, 1, 1, 0, 1, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] vld;
    logic [7:0] d0, d2, d3;
    logic [4:0] d1;
    logic [3:0] tx_v, rdy_v, busy_v, done_v;
    logic       chk_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    int         m_phase [4];
    logic [8:0] m_word  [4];

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst(rst), .tx_data(d0), .tx_valid(vld[0]),
        .tx_ready(rdy_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(vld[1]),
        .tx_ready(rdy_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) u2 (
        .clk(clk), .rst(rst), .tx_data(d2), .tx_valid(vld[2]),
        .tx_ready(rdy_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) u3 (
        .clk(clk), .rst(rst), .tx_data(d3), .tx_valid(vld[3]),
        .tx_ready(rdy_v[3]), .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

    function automatic int flen(input int i);
        return (1 + DB_P[i] + PAR_EN + SB_P[i]) * CPB;
    endfunction

    function automatic logic [8:0] cur_data(input int i);
        case (i)
            0:       return {1'b0, d0};
            1:       return {4'b0, d1};
            2:       return {1'b0, d2};
            default: return {1'b0, d3};
        endcase
    endfunction

    // Line level at position ph (1-based cycle within the frame) for a latched word.
    function automatic logic exp_tx(input int i, input int ph, input logic [8:0] w);
        int slot;
        if (ph < 1 || ph > flen(i)) return 1'b1;
        slot = (ph - 1) / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= DB_P[i]) return w[slot-1];
        if (PAR_EN == 1 && slot == DB_P[i] + 1) return (^w) ^ ODD_P[i][0];
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Model: phase 0 idle, 1..L frame cycles, L+1 the done/ready cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                m_phase[i] <= 0;
            end else if ((m_phase[i] == 0 || m_phase[i] == flen(i) + 1) && vld[i]) begin
                m_word[i]  <= cur_data(i);
                m_phase[i] <= 1;
            end else if (m_phase[i] >= 1 && m_phase[i] <= flen(i)) begin
                m_phase[i] <= m_phase[i] + 1;
            end else begin
                m_phase[i] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                int   ph;
                logic busy;
                ph   = m_phase[i];
                busy = (ph >= 1 && ph <= flen(i));
                check($sformatf("u%0d_tx", i),    9'(tx_v[i]),   9'(exp_tx(i, ph, m_word[i])));
                check($sformatf("u%0d_ready", i), 9'(rdy_v[i]),  9'(!busy));
                check($sformatf("u%0d_busy", i),  9'(busy_v[i]), 9'(busy));
                check($sformatf("u%0d_done", i),  9'(done_v[i]), 9'(ph == flen(i) + 1));
            end
        end
    end

    // Present a word at a negedge; returns at the negedge of cycle 1 after acceptance.
    task automatic send(input int i, input logic [8:0] w);
        case (i)
            0:       d0 = w[7:0];
            1:       d1 = w[4:0];
            2:       d2 = w[7:0];
            default: d3 = w[7:0];
        endcase
        vld[i] = 1'b1;
        @(negedge clk);
        vld[i] = 1'b0;
    endtask

    initial begin
        int l1, l2;
        rst = 1'b1;
        vld = 4'b0001;
        d0 = 8'hA5; d1 = '0; d2 = '0; d3 = '0;
        @(posedge clk);
        #1 chk_en = 1'b1;

        // reset held 3 cycles with tx_valid high: no frame
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_tx", 9'(tx_v[0]), 9'd1);
            check("rst_ready", 9'(rdy_v[0]), 9'd1);
            check("rst_done", 9'(done_v[0]), 9'd0);
        end
        rst = 1'b0;
        vld = 4'b0000;
        repeat (5) @(negedge clk);
        check("post_rst_idle_tx", 9'(tx_v[0]), 9'd1);
        $display("reset: done");

        // single 0xA5 frame
        send(0, 9'h0A5);
        for (int k = 1; k <= 41; k++) begin
            if (k > 1) @(negedge clk);
            if ((k - 2) % 4 == 0 && k <= 38)
                check($sformatf("a5_slot%0d", (k - 2) / 4), 9'(tx_v[0]), 9'(A5_SLOTS[(k - 2) / 4]));
            if (k == 1)  check("a5_ready_c1", 9'(rdy_v[0]), 9'd0);
            if (k == 40) check("a5_ready_c40", 9'(rdy_v[0]), 9'd0);
            if (k == 40) check("a5_done_c40", 9'(done_v[0]), 9'd0);
            if (k == 41) check("a5_done_c41", 9'(done_v[0]), 9'd1);
            if (k == 41) check("a5_ready_c41", 9'(rdy_v[0]), 9'd1);
        end
        $display("frame 0xA5 on u0: done");
        repeat (3) @(negedge clk);

        // back-to-back 0x00 then 0xFF with tx_valid held
        d0 = 8'h00;
        vld[0] = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 82; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 10) check("b2b_first_data0", 9'(tx_v[0]), 9'd0);
            if (k >= 37 && k <= 41) check("b2b_stop_high", 9'(tx_v[0]), 9'd1);
            if (k == 41) check("b2b_done1", 9'(done_v[0]), 9'd1);
            if (k == 42) check("b2b_start2", 9'(tx_v[0]), 9'd0);
            if (k == 46) check("b2b_ff_bit0", 9'(tx_v[0]), 9'd1);
            if (k == 81) check("b2b_no_early_done", 9'(done_v[0]), 9'd0);
            if (k == 82) check("b2b_done2", 9'(done_v[0]), 9'd1);
            if (k == 41) d0 = 8'hFF;
            if (k == 42) vld[0] = 1'b0;
        end
        $display("back-to-back 0x00,0xFF on u0: done");
        repeat (3) @(negedge clk);

        // 0x07 on the two-stop-bit instances (even and odd parity)
        l2 = flen(2);
        d2 = 8'h07; d3 = 8'h07;
        vld[2] = 1'b1; vld[3] = 1'b1;
        @(negedge clk);
        vld[2] = 1'b0; vld[3] = 1'b0;
        for (int k = 1; k <= l2 + 1; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 38) begin
                check("p07_even_bit", 9'(tx_v[2]), (PAR_EN == 1) ? 9'd1 : 9'd1);
                check("p07_odd_bit",  9'(tx_v[3]), (PAR_EN == 1) ? 9'd0 : 9'd1);
            end
            if (k == l2) check("p07_stop_last", 9'(tx_v[2]), 9'd1);
            if (k == l2 + 1) begin
                check("p07_done_even", 9'(done_v[2]), 9'd1);
                check("p07_done_odd", 9'(done_v[3]), 9'd1);
                check("p07_frame_len", 9'(l2), (PAR_EN == 1) ? 9'd48 : 9'd44);
            end
        end
        $display("frame 0x07 on u2/u3: done");
        repeat (3) @(negedge clk);

        // reset mid-frame
        send(0, 9'h055);
        for (int k = 1; k <= 15; k++) begin
            if (k > 1) @(negedge clk);
        end
        check("abort_bit2", 9'(tx_v[0]), 9'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx_high", 9'(tx_v[0]), 9'd1);
        check("abort_ready", 9'(rdy_v[0]), 9'd1);
        rst = 1'b0;
        for (int k = 17; k <= 50; k++) begin
            @(negedge clk);
            check("abort_no_done", 9'(done_v[0]), 9'd0);
        end
        send(0, 9'h03C);
        for (int k = 1; k <= 41; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 6)  check("w3c_bit0", 9'(tx_v[0]), 9'd0);
            if (k == 14) check("w3c_bit2", 9'(tx_v[0]), 9'd1);
            if (k == 41) check("w3c_done", 9'(done_v[0]), 9'd1);
        end
        $display("abort 0x55 then 0x3C on u0: done");
        repeat (3) @(negedge clk);

        // 5-bit word, input changed after accept
        l1 = flen(1);
        send(1, 9'h01B);
        d1 = 5'h00;
        for (int k = 1; k <= l1 + 1; k++) begin
            if (k > 1) @(negedge clk);
            if ((k - 2) % 4 == 0 && k <= 22)
                check($sformatf("w1b_slot%0d", (k - 2) / 4), 9'(tx_v[1]), 9'(W1B_SLOTS[(k - 2) / 4]));
            if (k == l1) check("w1b_done_early", 9'(done_v[1]), 9'd0);
            if (k == l1 + 1) begin
                check("w1b_done", 9'(done_v[1]), 9'd1);
                check("w1b_frame_len", 9'(l1), (PAR_EN == 1) ? 9'd32 : 9'd28);
            end
        end
        $display("frame 5'h1B on u1: done");
        repeat (5) @(negedge clk);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
